turfio_cout_serializer: RTL
===========================

Name: turfio_cout_serializer

Overview:
- SURF-side transmitter for the COUT response path toward the TURFIO; the counterpart of the CIN capture/parallelizer chain.
- Accepts 32-bit response words in the aclk domain and emits one 4-bit nibble per nibble strobe.
- Inserts a training word or an idle word at word boundaries when no response is queued.
- Its nibble output feeds the COUT OSERDES stage, which is outside this block.

Parameters:
- TRAIN_VALUE, 32'hA55A6996, word sent while training is enabled (matches the CIN training pattern).
- IDLE_VALUE, 32'h00000000, word sent when idle.
- MSB_FIRST, 1'b1, 1 = nibble [31:28] is sent first; 0 = nibble [3:0] is sent first.

Ports:
- aclk_i  in  1  system clock; the only clock.
- aclk_rstn_i  in  1  asynchronous, active-low reset.
- ce_i  in  1  nibble strobe (the aclk phase indicator); one nibble is emitted per asserted cycle.
- align_i  in  1  pulse: restart word framing on the next ce_i.
- train_en_i  in  1  send TRAIN_VALUE words in place of idle or data.
- response_i  in  32  response word.
- response_valid_i  in  1  response_i is valid.
- response_ready_o  out  1  block can accept a word this cycle.
- cout_o  out  4  serialized nibble toward the OSERDES.
- cout_valid_o  out  1  cout_o was updated this cycle (ce_i delayed by one cycle).
- word_start_o  out  1  cout_o holds nibble 0 of a word.
- sent_type_o  out  2  type of the word being sent: 0 = IDLE, 1 = TRAIN, 2 = DATA.

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low (aclk_i / aclk_rstn_i).
- Reset values:
  - cout_o = 0, cout_valid_o = 0, word_start_o = 0, sent_type_o = 0.
  - Nibble counter nib_cnt (3 bits) = 0; shift register = 0; holding register empty.
  - response_ready_o = 1 one cycle after reset deasserts.
- Holding register (1 entry):
  - response_ready_o = !hold_valid.
  - A word is captured when response_valid_i && response_ready_o.
  - The holding register is consumed only at a word load.
- Word load (ce_i && nib_cnt==0). Next-word select, in priority order:
  - train_en_i → TRAIN_VALUE, type TRAIN. A held word stays held.
  - else hold_valid → the held word, type DATA; hold_valid clears.
  - else IDLE_VALUE, type IDLE.
- Output on the load cycle:
  - cout_o ← first nibble of the selected word.
  - The shift register takes the remaining 28 bits.
  - word_start_o ← 1; sent_type_o ← the selected type.
- Other ce_i cycles:
  - cout_o ← next nibble; the shift register advances 4 bits.
  - word_start_o ← 0.
- nib_cnt increments mod 8 on every ce_i.
- Simultaneous capture and consume in the same cycle cannot occur: ready is low while hold_valid is set. Throughput is therefore one word per 8 ce_i.
- Latency: a word captured while the holding register is empty is loaded at the next nib_cnt==0 ce_i. Its first nibble appears on cout_o in the following cycle.
- No ce_i: the outputs hold their values; cout_valid_o = 0.
- align_i:
  - Forces nib_cnt to 0 in the following cycle. A word in flight is abandoned; the holding register is untouched.
  - If align_i and ce_i coincide, the ce_i is processed normally first, then nib_cnt is forced to 0.
- train_en_i changes take effect only at word boundaries. Words are never truncated by a train_en_i change.
- Reset mid-word: all state clears immediately. A held word is lost.

Optional Feature:
- Macro: TURFIO_COUT_FIFO_EN.
- Defined: the holding register becomes a 4-entry FIFO (2-bit pointers with wrap, plus a count).
  - response_ready_o = (count != 4).
  - Push and pop in the same cycle leave count unchanged.
  - At count==4 with a pop and no push, ready rises in the next cycle.
- Undefined: 1-entry holding register as described in Behaviour.

Decomposition:
- Shared package turfio_pkg:
  - TRAIN_VALUE and IDLE_VALUE constants.
  - enum cout_type_t {IDLE, TRAIN, DATA} (2 bits).
  - Nibble-count width constant (3).
- Sub-module turfio_cout_fifo: the holding stage. Depth 1 or 4 is selected by TURFIO_COUT_FIFO_EN; it has a valid/ready interface on both sides.

Test Plan:
- Reset, then idle with ce_i every 2nd cycle → 8 nibbles of 0x0; word_start_o every 16 cycles; sent_type_o = 0.
- train_en_i = 1 → nibble sequence A,5,5,A,6,9,9,6 repeating; sent_type_o = 1. Drop train_en_i mid-word → the word completes, then idle.
- Push 0x12345678 mid-idle-word → ready low until the next load; then 1,2,3,4,5,6,7,8 with sent_type_o = 2; ready high after the load.
- Two back-to-back valid words → the second waits 8 ce_i (ready low). With TURFIO_COUT_FIFO_EN, 4 words are accepted without stall and the 5th stalls.
- align_i at nib_cnt==5 → the next ce_i gives word_start_o = 1 and the held data word is sent intact; align_i coincident with ce_i is checked too.
- Assert aclk_rstn_i mid-data-word → outputs zero asynchronously; after release, idle words restart at nib_cnt 0.

Source files
------------

// File: rtl/turfio_pkg.sv
// rtl/turfio_pkg.sv - shared constants and word-type enum for the TURFIO COUT serializer
package turfio_pkg;

  localparam logic [31:0] TRAIN_VALUE = 32'hA55A6996;
  localparam logic [31:0] IDLE_VALUE  = 32'h00000000;
  localparam int          NIB_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    DATA  = 2'd2
  } cout_type_t;

endpackage

// File: rtl/turfio_cout_fifo.sv
// rtl/turfio_cout_fifo.sv - response holding stage; depth 4 with TURFIO_COUT_FIFO_EN, else depth 1
module turfio_cout_fifo
  import turfio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

`ifdef TURFIO_COUT_FIFO_EN
  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        push;
  logic        pop;

  assign in_ready  = (count != 3'd4);
  assign out_valid = (count != 3'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
`else
  logic [31:0] data_q;
  logic        full;

  assign in_ready  = !full;
  assign out_valid = full;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      data_q <= 32'h0;
    end else if (in_valid && in_ready) begin
      full   <= 1'b1;
      data_q <= in_data;
    end else if (out_valid && out_ready) begin
      full   <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/turfio_cout_serializer.sv
// rtl/turfio_cout_serializer.sv - COUT word-to-nibble serializer; TURFIO_COUT_FIFO_EN deepens holding stage
module turfio_cout_serializer
  import turfio_pkg::*;
#(
  parameter logic [31:0] TRAIN_VALUE = turfio_pkg::TRAIN_VALUE,
  parameter logic [31:0] IDLE_VALUE  = turfio_pkg::IDLE_VALUE,
  parameter logic        MSB_FIRST   = 1'b1
) (
  input  logic        aclk_i,
  input  logic        aclk_rstn_i,
  input  logic        ce_i,
  input  logic        align_i,
  input  logic        train_en_i,
  input  logic [31:0] response_i,
  input  logic        response_valid_i,
  output logic        response_ready_o,
  output logic [3:0]  cout_o,
  output logic        cout_valid_o,
  output logic        word_start_o,
  output logic [1:0]  sent_type_o
);

  logic [NIB_CNT_W-1:0] nib_cnt;
  logic [27:0]          shift;
  logic [31:0]          hold_data;
  logic                 hold_valid;
  logic                 load;
  logic [31:0]          sel_word;
  cout_type_t           sel_type;
  logic [3:0]           first_nib;
  logic [27:0]          rest;
  logic [3:0]           next_nib;
  logic [27:0]          shifted;

  assign load = ce_i && (nib_cnt == '0);

  // Training preempts data without consuming it, so the held word survives a training burst.
  turfio_cout_fifo u_fifo (
    .clk       (aclk_i),
    .rst_n     (aclk_rstn_i),
    .in_data   (response_i),
    .in_valid  (response_valid_i),
    .in_ready  (response_ready_o),
    .out_data  (hold_data),
    .out_valid (hold_valid),
    .out_ready (load && !train_en_i)
  );

  always_comb begin
    sel_word = IDLE_VALUE;
    sel_type = IDLE;
    if (train_en_i) begin
      sel_word = TRAIN_VALUE;
      sel_type = TRAIN;
    end else if (hold_valid) begin
      sel_word = hold_data;
      sel_type = DATA;
    end
  end

  assign first_nib = MSB_FIRST ? sel_word[31:28] : sel_word[3:0];
  assign rest      = MSB_FIRST ? sel_word[27:0]  : sel_word[31:4];
  assign next_nib  = MSB_FIRST ? shift[27:24]    : shift[3:0];
  assign shifted   = MSB_FIRST ? {shift[23:0], 4'h0} : {4'h0, shift[27:4]};

  always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
    if (!aclk_rstn_i) begin
      nib_cnt      <= '0;
      shift        <= 28'h0;
      cout_o       <= 4'h0;
      cout_valid_o <= 1'b0;
      word_start_o <= 1'b0;
      sent_type_o  <= 2'd0;
    end else begin
      cout_valid_o <= ce_i;
      if (load) begin
        cout_o       <= first_nib;
        shift        <= rest;
        word_start_o <= 1'b1;
        sent_type_o  <= sel_type;
      end else if (ce_i) begin
        cout_o       <= next_nib;
        shift        <= shifted;
        word_start_o <= 1'b0;
      end
      // Align wins over the increment but the coincident nibble is still emitted above.
      if (align_i)   nib_cnt <= '0;
      else if (ce_i) nib_cnt <= nib_cnt + 1'b1;
    end
  end

endmodule
